// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared types and constants for the branch tracking unit:
//               tracker state encoding, FIFO entry layout, PC step and
//               BHT counter reset value, plus the saturating counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    // Widest PC the FIFO entry can carry; narrower ADDR_WIDTH values are
    // zero-extended on entry and truncated on use.
    localparam int ENTRY_ADDR_WIDTH = 64;

    // Sequential instruction stride used for the fall-through address.
    localparam int PC_STEP = 4;

    // Weakly-not-taken starting point for every history counter.
    localparam logic [1:0] BHT_RESET = 2'b01;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [ENTRY_ADDR_WIDTH-1:0] pc;
        logic                        pred_taken;
        logic [ENTRY_ADDR_WIDTH-1:0] pred_target;
        logic                        is_jalr;
    } entry_t;

    // Two-bit saturating counter step: up on taken, down on not taken.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr,
                                              input logic       taken);
        logic [1:0] result;
        result = ctr;
        if (taken) begin
            if (ctr != 2'b11) begin
                result = ctr + 2'b01;
            end
        end else begin
            if (ctr != 2'b00) begin
                result = ctr - 2'b01;
            end
        end
        return result;
    endfunction

endpackage : branch_pkg
`default_nettype wire

// File: rtl/branch_history_table.sv
`default_nettype none
// ============================================================================
// Module      : branch_history_table
// Description : Array of 2-bit saturating direction counters indexed by
//               pc[log2(BHT_ENTRIES)+1:2]. Lookup is combinational and sees
//               the pre-update value when it collides with an update.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_history_table
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int BHT_ENTRIES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  lookup_taken,
    input  logic                  update_valid,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic                  update_taken
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       ctr [BHT_ENTRIES];
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] update_idx;

    // Word-aligned PCs: the two LSBs and the bits above the index do not
    // participate in the table lookup.
    assign lookup_idx = lookup_pc[IDX_W+1:2];
    assign update_idx = update_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[ADDR_WIDTH-1:IDX_W+2], lookup_pc[1:0],
                              update_pc[ADDR_WIDTH-1:IDX_W+2], update_pc[1:0]};

    // Prediction is the counter MSB: 2 and 3 mean taken.
    assign lookup_taken = ctr[lookup_idx][1];

    // Counter array: reinitialised on reset, one saturating step per update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctr[i] <= BHT_RESET;
            end
        end else if (update_valid) begin
            ctr[update_idx] <= sat_update(ctr[update_idx], update_taken);
        end
    end

endmodule : branch_history_table
`default_nettype wire

// File: rtl/branch_track_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_track_unit
// Description : Tracks up to DEPTH outstanding predicted control-flow
//               instructions between ID and EX. The oldest entry is checked
//               against each EX resolution; a mismatch produces a registered
//               one-cycle redirect + flush, empties the FIFO and blocks
//               allocation for FLUSH_CYCLES cycles. Owns the BHT used at
//               decode. Optional macro BTU_PERF_CNT_EN adds the
//               perf_resolved / perf_mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_track_unit
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH   = 64,
    parameter int DEPTH        = 4,
    parameter int BHT_ENTRIES  = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        lookup_pc,
    output logic                         lookup_taken,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic                         alloc_is_jalr,
    input  logic [ADDR_WIDTH-1:0]        alloc_pc,
    input  logic                         alloc_pred_taken,
    input  logic [ADDR_WIDTH-1:0]        alloc_pred_target,
    input  logic                         resolve_valid,
    input  logic                         resolve_taken,
    input  logic [ADDR_WIDTH-1:0]        resolve_target,
    output logic                         redirect_valid,
    output logic [ADDR_WIDTH-1:0]        redirect_pc,
    output logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         protocol_err
`ifdef BTU_PERF_CNT_EN
   ,output logic [CNT_WIDTH-1:0]         perf_resolved,
    output logic [CNT_WIDTH-1:0]         perf_mispredict
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
    // The redirect cycle itself is the first FLUSH cycle, so the down
    // counter is loaded with one less than the total.
    localparam logic [FC_W-1:0]  FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    entry_t                fifo_mem [DEPTH];
    logic [PTR_W-1:0]      head_ptr;
    logic [PTR_W-1:0]      tail_ptr;

    state_t                state;
    state_t                state_next;
    logic [FC_W-1:0]       flush_cnt;
    logic [FC_W-1:0]       flush_cnt_next;

    entry_t                head;
    entry_t                new_entry;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [ADDR_WIDTH-1:0] head_target;
    logic [ADDR_WIDTH-1:0] fall_through;
    logic [ADDR_WIDTH-1:0] actual_next;
    logic [ADDR_WIDTH-1:0] pred_next;

    logic                  push;
    logic                  pop;
    logic                  resolve_act;
    logic                  resolve_empty;
    logic                  mispredict;

    // ------------------------------------------------------------------
    // Head comparison: both sides reduce to "address of the next
    // instruction", so direction and target are checked in one compare.
    // ------------------------------------------------------------------
    assign head         = fifo_mem[head_ptr];
    assign head_pc      = head.pc[ADDR_WIDTH-1:0];
    assign head_target  = head.pred_target[ADDR_WIDTH-1:0];
    assign fall_through = head_pc + ADDR_WIDTH'(PC_STEP);

    assign actual_next  = (head.is_jalr || resolve_taken)   ? resolve_target : fall_through;
    assign pred_next    = (head.is_jalr || head.pred_taken) ? head_target    : fall_through;

    assign resolve_act   = resolve_valid && (state == RUN) && (count != '0);
    assign resolve_empty = resolve_valid && (state == RUN) && (count == '0);
    assign mispredict    = resolve_act && (actual_next != pred_next);
    assign pop           = resolve_act && !mispredict;

    // No pop bypass: a full FIFO stays closed even while the head retires.
    assign alloc_ready = !rst && (state == RUN) && (count < DEPTH_CNT);
    assign push        = alloc_valid && alloc_ready;

    // Pack the incoming instruction into the FIFO entry layout.
    always_comb begin
        new_entry             = '0;
        new_entry.pc          = ENTRY_ADDR_WIDTH'(alloc_pc);
        new_entry.pred_taken  = alloc_pred_taken;
        new_entry.pred_target = ENTRY_ADDR_WIDTH'(alloc_pred_target);
        new_entry.is_jalr     = alloc_is_jalr;
    end

    // ------------------------------------------------------------------
    // Tracker FSM
    // ------------------------------------------------------------------

    // State register and flush-window counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // Next state: enter FLUSH on mismatch, leave once the window expires.
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            RUN: begin
                if (mispredict) begin
                    state_next     = FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (flush_cnt == '0) begin
                    state_next = RUN;
                end else begin
                    flush_cnt_next = flush_cnt - FC_W'(1);
                end
            end
            default: begin
                state_next     = RUN;
                flush_cnt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO of outstanding predictions
    // ------------------------------------------------------------------

    // Entry storage; an alloc coinciding with a mismatch is dropped.
    always_ff @(posedge clk) begin
        if (push && !mispredict) begin
            fifo_mem[tail_ptr] <= new_entry;
        end
    end

    // Pointers and occupancy; a mismatch empties everything at once.
    always_ff @(posedge clk) begin
        if (rst || mispredict) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered redirect / flush / protocol-error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            protocol_err   <= 1'b0;
        end else begin
            redirect_valid <= mispredict;
            flush          <= mispredict;
            protocol_err   <= resolve_empty;
            if (mispredict) begin
                redirect_pc <= actual_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Direction predictor: trained only by conditional branches
    // ------------------------------------------------------------------
    branch_history_table #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BHT_ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk          (clk),
        .rst          (rst),
        .lookup_pc    (lookup_pc),
        .lookup_taken (lookup_taken),
        .update_valid (resolve_act && !head.is_jalr),
        .update_pc    (head_pc),
        .update_taken (resolve_taken)
    );

`ifdef BTU_PERF_CNT_EN
    // Free-running event counters, wrapping at 2^CNT_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_resolved   <= '0;
            perf_mispredict <= '0;
        end else begin
            if (resolve_act) begin
                perf_resolved <= perf_resolved + CNT_WIDTH'(1);
            end
            if (mispredict) begin
                perf_mispredict <= perf_mispredict + CNT_WIDTH'(1);
            end
        end
    end
`else
    // Counter width only matters when the counters exist; tie it off here.
    logic [CNT_WIDTH-1:0] unused_cnt_width_tie;
    assign unused_cnt_width_tie = '0;
`endif

endmodule : branch_track_unit
`default_nettype wire
